// File: rtl/imm_pkg.sv
// Shared encodings and RV32I immediate field positions for the immediate encoder
// and its matching extender.
package imm_pkg;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_U = 3'b001;
   localparam logic [2:0] IMM_J = 3'b010;
   localparam logic [2:0] IMM_B = 3'b011;
   localparam logic [2:0] IMM_S = 3'b100;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_RANGE = 2'b01;
   localparam logic [1:0] ERR_ALIGN = 2'b10;
   localparam logic [1:0] ERR_SEL   = 2'b11;

   // Instruction bit positions of each immediate field (LSB of the field, or single bit).
   localparam int I_LSB     = 20;   // [31:20] <- imm[11:0]
   localparam int U_LSB     = 12;   // [31:12] <- imm[31:12]
   localparam int S_HI_LSB  = 25;   // [31:25] <- imm[11:5]
   localparam int S_LO_LSB  = 7;    // [11:7]  <- imm[4:0]
   localparam int B_B12_POS = 31;   // [31]    <- imm[12]
   localparam int B_HI_LSB  = 25;   // [30:25] <- imm[10:5]
   localparam int B_LO_LSB  = 8;    // [11:8]  <- imm[4:1]
   localparam int B_B11_POS = 7;    // [7]     <- imm[11]
   localparam int J_B20_POS = 31;   // [31]    <- imm[20]
   localparam int J_LO_LSB  = 21;   // [30:21] <- imm[10:1]
   localparam int J_B11_POS = 20;   // [20]    <- imm[11]
   localparam int J_HI_LSB  = 12;   // [19:12] <- imm[19:12]

   typedef struct packed {
      logic [31:0] insn;
      logic [1:0]  err_code;
   } item_t;

   // Immediate extender: the decode-side inverse of the encoder's field placement.
   function automatic logic [31:0] imm_extend(input logic [31:0] insn, input logic [2:0] sel);
      logic [31:0] imm;
      imm = '0;
      case (sel)
         IMM_I: imm = {{20{insn[31]}}, insn[31:20]};
         IMM_U: imm = {insn[31:12], 12'h000};
         IMM_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         IMM_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         IMM_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/imm_range_check.sv
// Classifies an immediate for a given type: bad select, misalignment or out of
// the type's encodable range. Purely combinational.
module imm_range_check
   import imm_pkg::*;
(
   input  logic [31:0] imm,
   input  logic [2:0]  sel,
   output logic [1:0]  err_code
);

   logic fits_12;   // signed value fits in 12 bits (I/S)
   logic fits_13;   // signed value fits in 13 bits (B)
   logic fits_21;   // signed value fits in 21 bits (J)
   logic low_zero;  // no bits below the U field

   always_comb begin
      fits_12  = (&imm[31:11]) | ~(|imm[31:11]);
      fits_13  = (&imm[31:12]) | ~(|imm[31:12]);
      fits_21  = (&imm[31:20]) | ~(|imm[31:20]);
      low_zero = ~(|imm[11:0]);
   end

   // Priority: bad select, then misalignment, then range.
   always_comb begin
      err_code = ERR_NONE;
      case (sel)
         IMM_I, IMM_S: begin
            if (!fits_12)
               err_code = ERR_RANGE;
         end
         IMM_U: begin
            if (!low_zero)
               err_code = ERR_RANGE;
         end
         IMM_B: begin
            if (imm[0])
               err_code = ERR_ALIGN;
            else if (!fits_13)
               err_code = ERR_RANGE;
         end
         IMM_J: begin
            if (imm[0])
               err_code = ERR_ALIGN;
            else if (!fits_21)
               err_code = ERR_RANGE;
         end
         default: err_code = ERR_SEL;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Scatters a 32-bit immediate into the immediate fields of a base RV32I word,
// through a 2-stage valid/ready pipeline with error flagging and a saturating error counter.
module imm_encoder
   import imm_pkg::*;
#(
   parameter int ERR_CNT_W = 8
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_insn,
   input  logic [31:0]          in_imm,
   input  logic [2:0]           in_imm_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_insn,
   output logic                 out_err,
   output logic [1:0]           out_err_code,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 clr_err_count
);

   logic                 s1_valid_reg;
   item_t                s1_item_reg;
   logic                 out_valid_reg;
   item_t                s2_item_reg;
   logic [ERR_CNT_W-1:0] err_count_reg;
   logic [ERR_CNT_W-1:0] err_count_next;

   item_t                pack_next;
   logic [1:0]           chk_code;
   logic                 adv1;
   logic                 adv2;
   logic                 err_inc;

   assign adv2     = ~out_valid_reg | out_ready;
   assign adv1     = ~s1_valid_reg | adv2;
   assign in_ready = adv1;

   imm_range_check u_range_check (
      .imm      (in_imm),
      .sel      (in_imm_sel),
      .err_code (chk_code)
   );

   // Fields are packed even when the range check fails, so truncated bits land in place.
   always_comb begin
      pack_next.insn     = in_insn;
      pack_next.err_code = chk_code;
      case (in_imm_sel)
         IMM_I: begin
            pack_next.insn[I_LSB +: 12] = in_imm[11:0];
         end
         IMM_U: begin
            pack_next.insn[U_LSB +: 20] = in_imm[31:12];
         end
         IMM_S: begin
            pack_next.insn[S_HI_LSB +: 7] = in_imm[11:5];
            pack_next.insn[S_LO_LSB +: 5] = in_imm[4:0];
         end
         IMM_B: begin
            pack_next.insn[B_B12_POS]     = in_imm[12];
            pack_next.insn[B_HI_LSB +: 6] = in_imm[10:5];
            pack_next.insn[B_LO_LSB +: 4] = in_imm[4:1];
            pack_next.insn[B_B11_POS]     = in_imm[11];
         end
         IMM_J: begin
            pack_next.insn[J_B20_POS]      = in_imm[20];
            pack_next.insn[J_LO_LSB +: 10] = in_imm[10:1];
            pack_next.insn[J_B11_POS]      = in_imm[11];
            pack_next.insn[J_HI_LSB +: 8]  = in_imm[19:12];
         end
         default: begin
            pack_next.insn = in_insn;
         end
      endcase
   end

   // A clear that coincides with an errored delivery still counts that delivery.
   always_comb begin
      err_inc        = out_valid_reg & out_ready & out_err;
      err_count_next = err_count_reg;
      if (clr_err_count)
         err_count_next = err_inc ? ERR_CNT_W'(1) : '0;
      else if (err_inc && (err_count_reg != '1))
         err_count_next = err_count_reg + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_item_reg   <= '0;
         out_valid_reg <= 1'b0;
         s2_item_reg   <= '0;
         err_count_reg <= '0;
      end else begin
         if (adv1) begin
            s1_valid_reg <= in_valid;
            if (in_valid)
               s1_item_reg <= pack_next;
         end
         // An empty stage 1 drains the output valid but leaves the data registers untouched.
         if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
               s2_item_reg <= s1_item_reg;
         end
         err_count_reg <= err_count_next;
      end
   end

   assign out_valid    = out_valid_reg;
   assign out_insn     = s2_item_reg.insn;
   assign out_err_code = s2_item_reg.err_code;
   assign out_err      = |s2_item_reg.err_code;
   assign err_count    = err_count_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder: a per-bit field-map reference model and a
// scoreboard queue check order, content, latency, stalls, error counting and reset.
module tb_imm_encoder;

   localparam int CW      = 2;
   localparam int CNT_MAX = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_insn = '0;
   logic [31:0]   in_imm = '0;
   logic [2:0]    in_imm_sel = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_insn;
   logic          out_err;
   logic [1:0]    out_err_code;
   logic [CW-1:0] err_count;
   logic          clr_err_count = 1'b0;

   always #5 clk = ~clk;

   imm_encoder #(.ERR_CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_insn       (in_insn),
      .in_imm        (in_imm),
      .in_imm_sel    (in_imm_sel),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_insn      (out_insn),
      .out_err       (out_err),
      .out_err_code  (out_err_code),
      .err_count     (err_count),
      .clr_err_count (clr_err_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] insn;
      logic [1:0]  code;
      logic [31:0] imm;
      logic [2:0]  sel;
      int          acc_cyc;
      bit          lat;
   } exp_t;

   exp_t q[$];

   // Which immediate bit lands in instruction bit ib for a type (-1: base bit kept).
   function automatic int map_bit(input logic [2:0] sel, input int ib);
      case (sel)
         3'd0: return (ib >= 20) ? ib - 20 : -1;
         3'd1: return (ib >= 12) ? ib : -1;
         3'd4: begin
            if (ib >= 25) return ib - 20;
            if (ib >= 7 && ib <= 11) return ib - 7;
            return -1;
         end
         3'd3: begin
            if (ib == 31) return 12;
            if (ib >= 25) return ib - 20;
            if (ib >= 8 && ib <= 11) return ib - 7;
            if (ib == 7) return 11;
            return -1;
         end
         3'd2: begin
            if (ib == 31) return 20;
            if (ib >= 21) return ib - 20;
            if (ib == 20) return 11;
            if (ib >= 12) return ib;
            return -1;
         end
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] model_insn(input logic [31:0] base, input logic [31:0] imm,
                                              input logic [2:0] sel);
      logic [31:0] r;
      for (int ib = 0; ib < 32; ib++) begin
         int m;
         m = map_bit(sel, ib);
         r[ib] = (m < 0) ? base[ib] : imm[m];
      end
      return r;
   endfunction

   function automatic logic [1:0] model_code(input logic [2:0] sel, input logic [31:0] imm);
      longint s;
      s = longint'($signed(imm));
      if (sel > 3'd4) return 2'd3;
      if ((sel == 3'd3 || sel == 3'd2) && (s % 2 != 0)) return 2'd2;
      case (sel)
         3'd0, 3'd4: return (s >= -2048 && s <= 2047) ? 2'd0 : 2'd1;
         3'd3:       return (s >= -4096 && s <= 4095) ? 2'd0 : 2'd1;
         3'd2:       return (s >= -1048576 && s <= 1048575) ? 2'd0 : 2'd1;
         default:    return ((imm % 4096) == 0) ? 2'd0 : 2'd1;
      endcase
   endfunction

   function automatic logic [31:0] model_extend(input logic [31:0] insn, input logic [2:0] sel);
      logic [31:0] r;
      int          top;
      r   = '0;
      top = -1;
      for (int ib = 0; ib < 32; ib++) begin
         int m;
         m = map_bit(sel, ib);
         if (m >= 0) begin
            r[m] = insn[ib];
            if (m > top) top = m;
         end
      end
      if (sel != 3'd1 && top >= 0 && r[top])
         r = r | ~((32'd1 << (top + 1)) - 32'd1);
      return r;
   endfunction

   function automatic logic [31:0] gen_valid(input logic [2:0] sel);
      logic [31:0] r;
      r = $urandom;
      case (sel)
         3'd0, 3'd4: return {{20{r[11]}}, r[11:0]};
         3'd1:       return {r[31:12], 12'h000};
         3'd3:       return {{19{r[12]}}, r[12:1], 1'b0};
         default:    return {{11{r[20]}}, r[20:1], 1'b0};
      endcase
   endfunction

   int          cyc = 0;
   int          model_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_insn = '0;
   logic [1:0]  prev_code = '0;
   bit          last_in_ready = 1'b0;
   bit          dir_on = 1'b0;
   bit          dir_lat = 1'b0;
   logic [31:0] dir_insn = '0;
   logic [1:0]  dir_code = '0;

   // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
   task automatic cycle();
      exp_t e;
      bit   inc;
      @(negedge clk);
      cyc++;
      last_in_ready = in_ready;
      if (prev_stall) begin
         check_val("stall_valid", 32'(out_valid), 32'd1);
         check_val("stall_insn", out_insn, prev_insn);
         check_val("stall_code", 32'(out_err_code), 32'(prev_code));
      end
      prev_stall = out_valid && !out_ready;
      prev_insn  = out_insn;
      prev_code  = out_err_code;
      inc = 1'b0;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check_val("spurious_out", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check_val("out_insn", out_insn, e.insn);
            check_val("out_err_code", 32'(out_err_code), 32'(e.code));
            check_val("out_err", 32'(out_err), 32'(e.code != 2'd0));
            if (e.lat)
               check_val("latency", 32'(cyc - e.acc_cyc), 32'd2);
            if (e.code == 2'd0)
               check_val("round_trip", model_extend(out_insn, e.sel), e.imm);
            inc = (e.code != 2'd0);
         end
      end
      if (in_valid && in_ready) begin
         e.insn    = dir_on ? dir_insn : model_insn(in_insn, in_imm, in_imm_sel);
         e.code    = dir_on ? dir_code : model_code(in_imm_sel, in_imm);
         e.imm     = in_imm;
         e.sel     = in_imm_sel;
         e.acc_cyc = cyc;
         e.lat     = dir_lat;
         q.push_back(e);
      end
      if (clr_err_count)
         model_cnt = inc ? 1 : 0;
      else if (inc && model_cnt < CNT_MAX)
         model_cnt++;
      @(posedge clk);
      #1;
      check_val("err_count", 32'(err_count), 32'(model_cnt));
   endtask

   task automatic send(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] sel,
                       input bit d, input logic [31:0] di, input logic [1:0] dc, input bit lat);
      int guard;
      in_valid   = 1'b1;
      in_insn    = base;
      in_imm     = imm;
      in_imm_sel = sel;
      dir_on     = d;
      dir_insn   = di;
      dir_code   = dc;
      dir_lat    = lat;
      guard      = 0;
      do begin
         cycle();
         guard++;
      end while (!last_in_ready && guard < 100);
      if (!last_in_ready)
         check_val("send_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      dir_on   = 1'b0;
      dir_lat  = 1'b0;
   endtask

   task automatic drain();
      int g;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      g = 0;
      while (q.size() > 0 && g < 100) begin
         cycle();
         g++;
      end
      check_val("drain_left", 32'(q.size()), 32'd0);
      repeat (2) cycle();
   endtask

   task automatic rand_item(input bit valid_only, input logic [2:0] fixed_sel);
      in_insn    = $urandom;
      in_imm_sel = valid_only ? fixed_sel : 3'($urandom_range(0, 7));
      in_imm     = valid_only ? gen_valid(fixed_sel) : $urandom;
   endtask

   task automatic rand_run(input int n_items, input bit valid_only, input logic [2:0] sel);
      int done;
      int g;
      done = 0;
      g    = 0;
      rand_item(valid_only, sel);
      while (done < n_items && g < 4 * n_items + 100) begin
         in_valid  = ($urandom_range(0, 9) < 9);
         out_ready = ($urandom_range(0, 9) < 8);
         cycle();
         g++;
         if (in_valid && last_in_ready) begin
            done++;
            rand_item(valid_only, sel);
         end
      end
      check_val("rand_run_done", 32'(done), 32'(n_items));
      in_valid = 1'b0;
   endtask

   initial begin
      int sent;
      int c;
      int drop_c;
      int g;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_insn", out_insn, 32'd0);
      check_val("rst_out_err_code", 32'(out_err_code), 32'd0);
      check_val("rst_out_err", 32'(out_err), 32'd0);
      check_val("rst_err_count", 32'(err_count), 32'd0);
      rst_n = 1'b1;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed encodings with hand-computed words.
      send(32'h0000_0013, 32'hFFFF_F800, 3'd0, 1'b1, 32'h8000_0013, 2'd0, 1'b1);
      drain();
      send(32'h0000_0063, 32'h0000_0FFE, 3'd3, 1'b1, 32'h7E00_0FE3, 2'd0, 1'b1);
      send(32'h0000_0063, 32'h0000_1001, 3'd3, 1'b1, 32'h8000_0063, 2'd2, 1'b0);
      send(32'h0000_0037, 32'h1234_5001, 3'd1, 1'b1, 32'h1234_5037, 2'd1, 1'b0);
      send(32'hDEAD_BEEF, 32'h0000_0123, 3'd6, 1'b1, 32'hDEAD_BEEF, 2'd3, 1'b0);
      drain();

      // Burst of 8 with a 5-cycle output stall in the middle.
      sent   = 0;
      c      = 0;
      drop_c = -1;
      rand_item(1'b0, 3'd0);
      while (sent < 8 && c < 60) begin
         in_valid  = 1'b1;
         out_ready = !(c >= 3 && c < 8);
         cycle();
         if (c >= 3 && c < 8 && !last_in_ready && drop_c < 0)
            drop_c = c;
         if (last_in_ready) begin
            sent++;
            rand_item(1'b0, 3'd0);
         end
         c++;
      end
      check_val("burst_sent", 32'(sent), 32'd8);
      check_val("in_ready_drop", 32'(drop_c >= 3 && drop_c <= 5), 32'd1);
      drain();

      // Saturation of the 2-bit counter, then clear coinciding with an errored delivery.
      clr_err_count = 1'b1;
      cycle();
      clr_err_count = 1'b0;
      for (int i = 0; i < 5; i++)
         send($urandom, $urandom, 3'($urandom_range(5, 7)), 1'b0, 32'd0, 2'd0, 1'b0);
      drain();
      check_val("err_sat", 32'(err_count), 32'd3);
      send(32'h0000_0037, 32'h0000_0001, 3'd1, 1'b0, 32'd0, 2'd0, 1'b0);
      g = 0;
      while (!out_valid && g < 10) begin
         cycle();
         g++;
      end
      clr_err_count = 1'b1;
      cycle();
      clr_err_count = 1'b0;
      check_val("err_clr_inc", 32'(err_count), 32'd1);
      drain();

      // Random sweep of encodable immediates per type, then fully random items.
      for (int s = 0; s < 5; s++)
         rand_run(2000, 1'b1, 3'(s));
      rand_run(1000, 1'b0, 3'd0);
      drain();

      // Asynchronous reset in the middle of traffic.
      rand_run(20, 1'b0, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_out_valid", 32'(out_valid), 32'd0);
      check_val("arst_err_count", 32'(err_count), 32'd0);
      check_val("arst_out_insn", out_insn, 32'd0);
      check_val("arst_out_err_code", 32'(out_err_code), 32'd0);
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_val("arst_in_ready", 32'(in_ready), 32'd1);
      repeat (10) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
